sd_rx_xfer_ctrl: RTL and testbench

Sequencer for the SD receive DMA path. Takes a multi-block read request (base address, block size, block count), drives the `en`/`adr` controls of the RX FIFO filler, and counts the words the filler writes to memory over Wishbone. It rebases the filler at every block boundary, checks per-block CRC status from the SD data host, and enforces a word-progress timeout. It reports completion and error status to the register block.

---
 rtl/sd_pkg.sv | 22 ++
 rtl/sd_xfer_tmo.sv | 36 +++
 rtl/sd_rx_xfer_ctrl.sv | 147 ++++++++++++++
 tb/tb_sd_rx_xfer_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD receive transfer path.
//   xfer_state_t      : sequencer states
//   SD_ERR_*          : err_code encodings reported to the register block
//   SD_MAX_BLK_BYTES  : largest legal block size in bytes
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_REARM = 3'd3,
    ST_FIN   = 3'd4
  } xfer_state_t;

  localparam logic [1:0] SD_ERR_NONE  = 2'd0;
  localparam logic [1:0] SD_ERR_CRC   = 2'd1;
  localparam logic [1:0] SD_ERR_TMO   = 2'd2;
  localparam logic [1:0] SD_ERR_ABORT = 2'd3;

  localparam int SD_MAX_BLK_BYTES = 2048;

endpackage

// File: rtl/sd_xfer_tmo.sv
// Reloadable word-progress timeout counter.
//   clk, rst_n : clock, async active-low reset
//   clear      : reload the counter to 0 (word ack seen, or not running)
//   run        : count while high
//   limit      : cycles allowed without a clear; 0 disables
//   expired    : high in the cycle the count reaches limit
module sd_xfer_tmo #(
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             run,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  logic [TMO_W-1:0] cnt;
  logic [TMO_W:0]   cnt_inc;

  // One bit wider so a limit of all-ones cannot be skipped by wrap.
  assign cnt_inc = {1'b0, cnt} + 1'b1;
  // Combinational so the sequencer reaches FIN on the cycle the count
  // would hit the limit, not one cycle later.
  assign expired = run && !clear && (limit != '0) && (cnt_inc == {1'b0, limit});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear || !run)
      cnt <= '0;
    else if (!expired)
      cnt <= cnt_inc[TMO_W-1:0];
  end

endmodule

// File: rtl/sd_rx_xfer_ctrl.sv
// Multi-block SD receive DMA sequencer. Drives the RX FIFO filler's
// enable/base address, counts committed words, rebases at each block
// boundary, and reports completion / error status.
//   clk, rst_n              : clock, async active-low reset
//   start, abort            : single-cycle request / cancel
//   base_adr, blk_size,
//   blk_cnt, tmo_cycles     : transfer parameters
//   word_ack                : one pulse per word the filler commits
//   blk_crc_ok, blk_crc_err : per-block CRC status from the data host
//   fill_en, fill_adr       : filler controls
//   busy, done, err_code,
//   blks_left               : status to the register block
module sd_rx_xfer_ctrl
  import sd_pkg::*;
#(
  parameter int BLKSZ_W  = 12,
  parameter int BLKCNT_W = 16,
  parameter int TMO_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [31:0]         base_adr,
  input  logic [BLKSZ_W-1:0]  blk_size,
  input  logic [BLKCNT_W-1:0] blk_cnt,
  input  logic [TMO_W-1:0]    tmo_cycles,
  input  logic                word_ack,
  input  logic                blk_crc_ok,
  input  logic                blk_crc_err,
  output logic                fill_en,
  output logic [31:0]         fill_adr,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err_code,
  output logic [BLKCNT_W-1:0] blks_left
);

  localparam int WC_W = BLKSZ_W - 2;

  xfer_state_t     state, state_nxt;
  logic [1:0]      err_nxt;
  logic [WC_W-1:0] wpb, wcnt, wcnt_inc;
  logic            counting, blk_end, blk_commit, tmo_exp;

  // Good-CRC pulses and the sub-word size bits carry no sequencing meaning.
  logic unused;
  assign unused = &{1'b0, blk_crc_ok, blk_size[1:0]};

  // Acks landing in REARM are real words from the filler and still count.
  assign counting   = word_ack && (state == ST_RUN || state == ST_REARM);
  assign wcnt_inc   = wcnt + 1'b1;
  assign blk_end    = counting && (wcnt_inc == wpb);
  assign blk_commit = blk_end && !abort && !blk_crc_err;

  sd_xfer_tmo #(.TMO_W(TMO_W)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (word_ack || state != ST_RUN),
    .run     (state == ST_RUN),
    .limit   (tmo_cycles),
    .expired (tmo_exp)
  );

  // Error sources are checked in priority order: abort, CRC, timeout,
  // then the normal block-complete path.
  always_comb begin
    state_nxt = state;
    err_nxt   = err_code;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_ARM;
          err_nxt   = SD_ERR_NONE;
        end
      end
      ST_ARM: begin
        if (abort) begin
          state_nxt = ST_FIN;
          err_nxt   = SD_ERR_ABORT;
        end else if (blk_crc_err) begin
          state_nxt = ST_FIN;
          err_nxt   = SD_ERR_CRC;
        end else if (wpb == '0 || blks_left == '0) begin
          state_nxt = ST_FIN;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN, ST_REARM: begin
        if (abort) begin
          state_nxt = ST_FIN;
          err_nxt   = SD_ERR_ABORT;
        end else if (blk_crc_err) begin
          state_nxt = ST_FIN;
          err_nxt   = SD_ERR_CRC;
        end else if (tmo_exp) begin
          state_nxt = ST_FIN;
          err_nxt   = SD_ERR_TMO;
        end else if (blk_end) begin
          state_nxt = (blks_left == BLKCNT_W'(1)) ? ST_FIN : ST_REARM;
        end else if (state == ST_REARM) begin
          state_nxt = ST_RUN;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      err_code  <= SD_ERR_NONE;
      busy      <= 1'b0;
      done      <= 1'b0;
      fill_en   <= 1'b0;
      fill_adr  <= '0;
      blks_left <= '0;
      wpb       <= '0;
      wcnt      <= '0;
    end else begin
      state    <= state_nxt;
      err_code <= err_nxt;
      busy     <= (state_nxt != ST_IDLE);
      done     <= (state_nxt == ST_FIN);
      fill_en  <= (state_nxt == ST_RUN);
      if (state == ST_IDLE && start) begin
        fill_adr  <= base_adr;
        wpb       <= blk_size[BLKSZ_W-1:2];
        blks_left <= blk_cnt;
        wcnt      <= '0;
      end else if (blk_commit) begin
        wcnt      <= '0;
        blks_left <= blks_left - 1'b1;
        // Rebase only when another block follows; the last block leaves
        // fill_adr pointing at itself.
        if (blks_left != BLKCNT_W'(1))
          fill_adr <= fill_adr + 32'({wpb, 2'b00});
      end else if (counting) begin
        wcnt <= wcnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_sd_rx_xfer_ctrl.sv
module tb_sd_rx_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [31:0] base_adr = '0;
  logic [11:0] blk_size = '0;
  logic [15:0] blk_cnt = '0;
  logic [15:0] tmo_cycles = '0;
  logic        word_ack = 1'b0, blk_crc_ok = 1'b0, blk_crc_err = 1'b0;
  logic        fill_en, busy, done;
  logic [31:0] fill_adr;
  logic [1:0]  err_code;
  logic [15:0] blks_left;

  int n_chk = 0;
  int n_err = 0;

  sd_rx_xfer_ctrl #(.BLKSZ_W(12), .BLKCNT_W(16), .TMO_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .base_adr    (base_adr),
    .blk_size    (blk_size),
    .blk_cnt     (blk_cnt),
    .tmo_cycles  (tmo_cycles),
    .word_ack    (word_ack),
    .blk_crc_ok  (blk_crc_ok),
    .blk_crc_err (blk_crc_err),
    .fill_en     (fill_en),
    .fill_adr    (fill_adr),
    .busy        (busy),
    .done        (done),
    .err_code    (err_code),
    .blks_left   (blks_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with the given parameters; returns in the ARM cycle.
  task automatic go(input logic [31:0] b, input logic [11:0] sz,
                    input logic [15:0] cnt, input logic [15:0] tmo);
    base_adr = b; blk_size = sz; blk_cnt = cnt; tmo_cycles = tmo;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_fill_en"},   32'(fill_en),   0);
    chk({tag, "_fill_adr"},  fill_adr,       0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_done"},      32'(done),      0);
    chk({tag, "_err"},       32'(err_code),  0);
    chk({tag, "_blks_left"}, 32'(blks_left), 0);
  endtask

  initial begin
    int lows, nd, fen;

    // ---- reset values ----
    #3;
    chk_reset("rst");
    #9 rst_n = 1'b1;
    tick();
    chk_reset("post_rst");

    // ---- nominal: 3 x 512-byte blocks, continuous acks ----
    go(32'h1000, 12'd512, 16'd3, 16'd0);
    chk("nom_arm_busy",  32'(busy),    1);
    chk("nom_arm_fen",   32'(fill_en), 0);
    chk("nom_arm_adr",   fill_adr,     32'h1000);
    tick();
    chk("nom_run_fen",   32'(fill_en), 1);
    lows = 0; nd = 0;
    for (int i = 0; i < 384; i++) begin
      word_ack   = 1'b1;
      start      = (i == 10);        // ignored while busy
      base_adr   = (i == 10) ? 32'h8000 : 32'h1000;
      blk_crc_ok = (i == 127);
      tick();
      if (done) nd++;
      if (i < 383 && !fill_en) lows++;
      if (i == 127) begin
        chk("nom_b1_fen", 32'(fill_en),   0);
        chk("nom_b1_adr", fill_adr,       32'h1200);
        chk("nom_b1_left", 32'(blks_left), 2);
      end
      if (i == 128) chk("nom_b1_fen_back", 32'(fill_en), 1);
      if (i == 255) begin
        chk("nom_b2_fen", 32'(fill_en), 0);
        chk("nom_b2_adr", fill_adr,     32'h1400);
      end
    end
    word_ack = 1'b0; start = 1'b0; blk_crc_ok = 1'b0;
    chk("nom_done",     32'(done),      1);
    chk("nom_err",      32'(err_code),  0);
    chk("nom_left",     32'(blks_left), 0);
    chk("nom_fin_busy", 32'(busy),      1);
    chk("nom_fen_lows", 32'(lows),      2);
    tick();
    if (done) nd++;
    chk("nom_done_cnt", 32'(nd),        1);
    chk("nom_idle_busy", 32'(busy),     0);

    // ---- timeout: limit 20, 10 acks then silence ----
    go(32'h0, 12'd512, 16'd1, 16'd20);
    tick();
    for (int i = 0; i < 10; i++) begin
      word_ack = 1'b1;
      tick();
    end
    word_ack = 1'b0;
    nd = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (done) nd++;
    end
    chk("tmo_early_done", 32'(nd), 0);
    tick();
    chk("tmo_done", 32'(done),     1);
    chk("tmo_err",  32'(err_code), 2);
    tick();

    // ---- degenerate: blk_cnt 0, then blk_size 3 ----
    fen = 0;
    go(32'h40, 12'd512, 16'd0, 16'd0);
    chk("deg0_err_cleared", 32'(err_code), 0);
    chk("deg0_arm_done",    32'(done),     0);
    if (fill_en) fen++;
    tick();
    if (fill_en) fen++;
    chk("deg0_done", 32'(done),     1);
    chk("deg0_err",  32'(err_code), 0);
    tick();
    if (fill_en) fen++;
    go(32'h40, 12'd3, 16'd2, 16'd0);
    if (fill_en) fen++;
    chk("deg3_arm_done", 32'(done), 0);
    tick();
    if (fill_en) fen++;
    chk("deg3_done", 32'(done),     1);
    chk("deg3_err",  32'(err_code), 0);
    tick();
    if (fill_en) fen++;
    chk("deg_fen_never", 32'(fen), 0);

    // ---- timeout disabled: no done for 1000 cycles ----
    go(32'h0, 12'd512, 16'd1, 16'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      word_ack = 1'b1;
      tick();
    end
    word_ack = 1'b0;
    nd = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (done) nd++;
    end
    chk("tmo0_no_done", 32'(nd),   0);
    chk("tmo0_busy",    32'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_done", 32'(done),     1);
    chk("abort_err",  32'(err_code), 3);
    tick();

    // ---- CRC error beats the final ack ----
    go(32'h0, 12'd8, 16'd1, 16'd0);
    tick();
    word_ack = 1'b1;
    tick();
    blk_crc_err = 1'b1;
    tick();
    word_ack = 1'b0; blk_crc_err = 1'b0;
    chk("crc_done", 32'(done),      1);
    chk("crc_err",  32'(err_code),  1);
    chk("crc_left", 32'(blks_left), 1);
    start = 1'b1;                    // ignored in FIN
    tick();
    start = 1'b0;
    chk("fin_start_ign", 32'(busy), 0);
    tick();
    chk("fin_start_ign2", 32'(busy), 0);

    // ---- abort beats CRC error ----
    go(32'h0, 12'd8, 16'd1, 16'd0);
    tick();
    abort = 1'b1; blk_crc_err = 1'b1;
    tick();
    abort = 1'b0; blk_crc_err = 1'b0;
    chk("prio_done", 32'(done),     1);
    chk("prio_err",  32'(err_code), 3);
    tick();

    // ---- reset during block 2 of 4, then a clean wrapping transfer ----
    go(32'h2000, 12'd8, 16'd4, 16'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      word_ack = 1'b1;
      tick();
    end
    word_ack = 1'b0;
    chk("mid_adr",  fill_adr,        32'h2008);
    chk("mid_left", 32'(blks_left),  3);
    #1 rst_n = 1'b0;
    #2;
    chk_reset("async_rst");
    #1 rst_n = 1'b1;
    tick();
    chk_reset("after_rst");
    go(32'hFFFF_FFF8, 12'd8, 16'd2, 16'd0);
    chk("re_arm_adr", fill_adr, 32'hFFFF_FFF8);
    tick();
    chk("re_run_fen", 32'(fill_en), 1);
    for (int i = 0; i < 4; i++) begin
      word_ack = 1'b1;
      tick();
      if (i == 1) chk("re_wrap_adr", fill_adr, 32'h0000_0000);
    end
    word_ack = 1'b0;
    chk("re_done", 32'(done),      1);
    chk("re_err",  32'(err_code),  0);
    chk("re_left", 32'(blks_left), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
